// File: rtl/total_amount_acc.sv
// -----------------------------------------------------------------------------
// total_amount_acc
//    Credit accumulator for the vending machine. Adds each presented coin to a
//    running credit, clears the credit on cancel (reporting the refunded
//    amount), and rejects any coin that would push the credit above
//    MAX_AMOUNT. All outputs are registered.
//
// Parameters
//    WIDTH          width of coin_value, current_amount, refund_amount
//    MAX_AMOUNT     highest credit that may be held (<= 2**WIDTH - 1)
//
// Ports
//    clk            rising-edge clock
//    rst            synchronous reset, active-high
//    cancel         clears the credit this cycle (level-sampled)
//    coin_value     value of the coin presented this cycle, 0 = no coin
//    current_amount running credit
//    refund_valid   one-cycle pulse: a non-zero credit was cancelled
//    refund_amount  credit being refunded while refund_valid, else 0
//    coin_rejected  one-cycle pulse: this cycle's coin was not credited
// -----------------------------------------------------------------------------
module total_amount_acc #(
   parameter int unsigned WIDTH      = 5,
   parameter int unsigned MAX_AMOUNT = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cancel,
   input  logic [WIDTH-1:0] coin_value,
   output logic [WIDTH-1:0] current_amount,
   output logic             refund_valid,
   output logic [WIDTH-1:0] refund_amount,
   output logic             coin_rejected
);

   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_AMOUNT);

   logic             coin_present;
   logic [WIDTH:0]   sum;
   logic             fits;

   // One extra bit on the sum so an overflowing coin is detected rather than
   // wrapping back into range.
   always_comb begin
      coin_present = |coin_value;
      sum          = {1'b0, current_amount} + {1'b0, coin_value};
      fits         = (sum <= MAX_EXT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         current_amount <= '0;
         refund_valid   <= 1'b0;
         refund_amount  <= '0;
         coin_rejected  <= 1'b0;
      end else if (cancel) begin
         // A coin arriving with cancel is handed back, never credited.
         current_amount <= '0;
         refund_valid   <= |current_amount;
         refund_amount  <= current_amount;
         coin_rejected  <= coin_present;
      end else begin
         refund_valid  <= 1'b0;
         refund_amount <= '0;
         if (coin_present && fits) begin
            current_amount <= sum[WIDTH-1:0];
            coin_rejected  <= 1'b0;
         end else if (coin_present) begin
            coin_rejected  <= 1'b1;
         end else begin
            coin_rejected  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_total_amount_acc.sv
module tb_total_amount_acc;

   localparam int unsigned WIDTH = 5;

   logic             clk;
   logic             rst;
   logic             cancel;
   logic [WIDTH-1:0] coin_value;
   logic [WIDTH-1:0] current_amount;
   logic             refund_valid;
   logic [WIDTH-1:0] refund_amount;
   logic             coin_rejected;

   int compared;
   int mismatched;

   total_amount_acc #(
      .WIDTH      (WIDTH),
      .MAX_AMOUNT (31)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cancel         (cancel),
      .coin_value     (coin_value),
      .current_amount (current_amount),
      .refund_valid   (refund_valid),
      .refund_amount  (refund_amount),
      .coin_rejected  (coin_rejected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
   task automatic step(input logic r, input logic c, input logic [WIDTH-1:0] coin);
      rst        = r;
      cancel     = c;
      coin_value = coin;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Checks all four outputs against expected values.
   task automatic check_all(input string tag, input int amt, input int rv,
                            input int ra, input int rej);
      check({tag, ".amount"}, int'(current_amount), amt);
      check({tag, ".refund_valid"}, int'(refund_valid), rv);
      check({tag, ".refund_amount"}, int'(refund_amount), ra);
      check({tag, ".coin_rejected"}, int'(coin_rejected), rej);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      cancel     = 1'b0;
      coin_value = '0;
      @(negedge clk);

      // Reset with a coin presented: everything cleared.
      step(1'b1, 1'b0, 5'd7);
      check_all("reset", 0, 0, 0, 0);

      // Accumulate back-to-back coins.
      step(1'b0, 1'b0, 5'd1);
      check_all("acc1", 1, 0, 0, 0);
      step(1'b0, 1'b0, 5'd5);
      check_all("acc6", 6, 0, 0, 0);
      step(1'b0, 1'b0, 5'd10);
      check_all("acc16", 16, 0, 0, 0);

      // Cancel with a coin present: refund 16, coin returned.
      step(1'b0, 1'b1, 5'd10);
      check_all("cancel_coin", 0, 1, 16, 1);
      step(1'b0, 1'b0, 5'd0);
      check_all("post_cancel_idle", 0, 0, 0, 0);

      // Accumulate after cancel.
      step(1'b0, 1'b0, 5'd2);
      check_all("after_cancel2", 2, 0, 0, 0);
      step(1'b0, 1'b0, 5'd3);
      check_all("after_cancel5", 5, 0, 0, 0);

      // Clear then build to 30.
      step(1'b0, 1'b1, 5'd0);
      check_all("cancel5", 0, 1, 5, 0);
      step(1'b0, 1'b0, 5'd20);
      check_all("build20", 20, 0, 0, 0);
      step(1'b0, 1'b0, 5'd10);
      check_all("build30", 30, 0, 0, 0);

      // Reaching MAX exactly is legal; next coin is rejected.
      step(1'b0, 1'b0, 5'd1);
      check_all("sat31", 31, 0, 0, 0);
      step(1'b0, 1'b0, 5'd1);
      check_all("sat_reject", 31, 0, 0, 1);
      step(1'b0, 1'b0, 5'd0);
      check_all("sat_idle", 31, 0, 0, 0);
      // Largest coin at full credit: 62 would wrap to 30 without the carry bit.
      step(1'b0, 1'b0, 5'd31);
      check_all("sat_big", 31, 0, 0, 1);

      // Back-to-back cancels: only the first pulses.
      step(1'b0, 1'b1, 5'd0);
      check_all("cancel31", 0, 1, 31, 0);
      step(1'b0, 1'b1, 5'd0);
      check_all("cancel_zero", 0, 0, 0, 0);

      // Reset beats cancel: no refund pulse.
      step(1'b0, 1'b0, 5'd9);
      check_all("build9", 9, 0, 0, 0);
      step(1'b1, 1'b1, 5'd4);
      check_all("rst_cancel", 0, 0, 0, 0);
      step(1'b0, 1'b0, 5'd0);
      check_all("after_rst", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
